// File: rtl/store_buffer.sv
// Posted-write buffer between the CPU memory stage and dmem: in-order drain when the port is idle,
// youngest-match forwarding to loads. Push is zero-wait unless full; a load blocks draining for that cycle.
module store_buffer #(
    parameter int n     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [n-1:0] st_addr,
    input  logic [n-1:0] st_data,
    input  logic         ld_req,
    input  logic [n-1:0] ld_addr,
    output logic [n-1:0] ld_data,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_writedata,
    input  logic [n-1:0] mem_readdata,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [n-3:0]  addr_q [DEPTH];
    logic [n-1:0]  data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, drain;
    logic          fwd_hit;
    logic [n-1:0]  fwd_data;
    logic [PW-1:0] fwd_idx;
    logic          unused_st_lsb;

    assign unused_st_lsb = ^st_addr[1:0];

    assign st_ready = (count_q != FULL);
    assign empty    = (count_q == '0);
    assign push     = st_valid && st_ready;
    assign drain    = !empty && !ld_req;

    assign mem_we        = drain;
    assign mem_addr      = ld_req ? ld_addr : {addr_q[head_q], 2'b00};
    assign mem_writedata = data_q[head_q];

    always_comb begin
        head_d  = drain ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        case ({push, drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset: count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr[n-1:2];
            data_q[tail_q] <= st_data;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[fwd_idx] == ld_addr[n-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    assign ld_data = fwd_hit ? fwd_data : mem_readdata;

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-plus-memory reference model.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int WORDS = 16384;

    logic        clk, reset;
    logic        st_valid, st_ready, ld_req, mem_we, empty;
    logic [15:0] st_addr, st_data, ld_addr, ld_data;
    logic [15:0] mem_addr, mem_writedata, mem_readdata;

    store_buffer #(.n(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dmem stand-in: combinational read, write at the rising edge
    logic [15:0] dmem [WORDS];
    assign mem_readdata = dmem[mem_addr[15:2]];
    always @(posedge clk) if (mem_we) dmem[mem_addr[15:2]] <= mem_writedata;

    // Reference: pending stores in program order, plus what memory must hold
    typedef struct { logic [13:0] w; logic [15:0] d; } ent_t;
    ent_t        q[$];
    logic [15:0] ref_mem [WORDS];

    int n_err = 0;
    int n_chk = 0;
    bit store_acc;

    function automatic logic [15:0] old_val(input int i);
        return 16'(i) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_load(input logic [15:0] a);
        for (int k = q.size() - 1; k >= 0; k--)
            if (q[k].w == a[15:2]) return q[k].d;
        return ref_mem[a[15:2]];
    endfunction

    task automatic drive(input bit sv, input logic [15:0] sa, input logic [15:0] sd,
                         input bit lr, input logic [15:0] la);
        st_valid = sv; st_addr = sa; st_data = sd; ld_req = lr; ld_addr = la;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        bit do_push, do_drain;
        @(negedge clk);
        chk("st_ready", 16'(st_ready), 16'(q.size() != DEPTH));
        chk("empty", 16'(empty), 16'(q.size() == 0));
        do_drain = (q.size() != 0) && !ld_req;
        chk("mem_we", 16'(mem_we), 16'(do_drain));
        if (do_drain) begin
            chk("mem_addr_drain", mem_addr, {q[0].w, 2'b00});
            chk("mem_writedata", mem_writedata, q[0].d);
        end
        if (ld_req) begin
            chk("mem_addr_load", mem_addr, ld_addr);
            chk("ld_data", ld_data, exp_load(ld_addr));
        end
        do_push = st_valid && (q.size() != DEPTH);
        store_acc = do_push;
        @(posedge clk);
        #1;
        if (do_drain) begin
            ref_mem[q[0].w] = q[0].d;
            void'(q.pop_front());
        end
        if (do_push) q.push_back('{w: st_addr[15:2], d: st_data});
    endtask

    task automatic drain_all();
        drive(0, 16'h0, 16'h0, 0, 16'h0);
        for (int k = 0; k < 3 * DEPTH && q.size() != 0; k++) step();
        chk("drain_done", 16'(q.size()), 16'd0);
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            dmem[i]    = old_val(i);
            ref_mem[i] = old_val(i);
        end
        drive(0, 16'h0, 16'h0, 0, 16'h0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_st_ready", 16'(st_ready), 16'd1);
        chk("rst_empty", 16'(empty), 16'd1);
        chk("rst_mem_we", 16'(mem_we), 16'd0);
        reset = 1'b0;

        // single store then drain
        drive(1, 16'h0008, 16'hBEEF, 0, 16'h0);
        step();
        drive(0, 16'h0, 16'h0, 0, 16'h0);
        #1;
        chk("single_we", 16'(mem_we), 16'd1);
        chk("single_addr", mem_addr, 16'h0008);
        chk("single_wdata", mem_writedata, 16'hBEEF);
        step();
        chk("single_empty", 16'(empty), 16'd1);
        chk("single_dmem", dmem[2], 16'hBEEF);

        // youngest match wins
        drive(1, 16'h0010, 16'h1111, 1, 16'h0012);
        step();
        drive(1, 16'h0010, 16'h2222, 1, 16'h0012);
        step();
        drive(0, 16'h0, 16'h0, 1, 16'h0012);
        #1;
        chk("fwd_youngest", ld_data, 16'h2222);
        step();
        drain_all();
        chk("fwd_dmem", dmem[4], 16'h2222);

        // full and back-pressure
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 16'(16'h0100 + i * 4), 16'(16'hF000 + i), 1, 16'h0200);
            step();
        end
        drive(1, 16'h0030, 16'h5555, 1, 16'h0200);
        #1;
        chk("full_not_ready", 16'(st_ready), 16'd0);
        step();
        ld_req = 1'b0;
        #1;
        chk("full_drain_not_ready", 16'(st_ready), 16'd0);
        chk("full_drain_we", 16'(mem_we), 16'd1);
        step();
        ld_req = 1'b1;
        #1;
        chk("full_ready_after", 16'(st_ready), 16'd1);
        step();
        st_valid = 1'b0;
        #1;
        chk("full_again", 16'(st_ready), 16'd0);
        drain_all();

        // push and drain in the same cycle
        drive(1, 16'h0028, 16'h0A01, 1, 16'h0300);
        step();
        drive(1, 16'h002C, 16'h0A02, 1, 16'h0300);
        step();
        drive(1, 16'h0020, 16'h00AA, 0, 16'h0);
        step();
        drive(0, 16'h0, 16'h0, 0, 16'h0);
        #1;
        chk("pd_head", mem_addr, 16'h002C);
        step();
        chk("pd_last_addr", mem_addr, 16'h0020);
        chk("pd_last_data", mem_writedata, 16'h00AA);
        step();
        chk("pd_empty", 16'(empty), 16'd1);

        // ten stores wrap the pointers, loads interleaved
        for (int i = 0; i < 10; i++) begin
            drive(1, 16'(i * 4), 16'(16'hC000 + i), i[0], 16'(i * 4));
            step();
            for (int r = 0; r < 8 && !store_acc; r++) begin
                ld_req = 1'b0;
                step();
            end
            chk("wrap_accept", 16'(store_acc), 16'd1);
        end
        drive(0, 16'h0, 16'h0, 1, 16'h0026);
        #1;
        chk("wrap_fwd_before", ld_data, 16'hC009);
        step();
        drain_all();
        drive(0, 16'h0, 16'h0, 1, 16'h0024);
        #1;
        chk("wrap_fwd_after", ld_data, 16'hC009);
        step();

        // reset mid-cycle discards pending stores
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'(16'h0040 + i * 4), 16'(16'hD001 + i), 1, 16'h0300);
            step();
        end
        drive(0, 16'h0, 16'h0, 0, 16'h0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_empty", 16'(empty), 16'd1);
        chk("midrst_we", 16'(mem_we), 16'd0);
        chk("midrst_ready", 16'(st_ready), 16'd1);
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 16'h0, 16'h0, 1, 16'(16'h0040 + i * 4));
            #1;
            chk("midrst_load", ld_data, old_val(16 + i));
            step();
        end

        // randomized traffic with CPU hold-on-stall semantics
        begin
            bit pend = 0;
            int ld_pct = 50;
            for (int c = 0; c < 1500; c++) begin
                if (c % 100 == 0) ld_pct = (c / 100) % 3 == 0 ? 90 : ((c / 100) % 3 == 1 ? 10 : 50);
                if (!pend) begin
                    st_valid = ($urandom_range(0, 2) != 0);
                    st_addr  = 16'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                    st_data  = 16'($urandom);
                end
                ld_req  = ($urandom_range(0, 99) < ld_pct);
                ld_addr = 16'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                step();
                pend = st_valid && !store_acc;
            end
        end
        drain_all();
        step();

        for (int i = 0; i < 64; i++) chk("dmem_final", dmem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
